// File: rtl/seg7_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the 7-segment display controller.
interface seg7_display_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/seg7_display_ctrl.sv
// Multi-digit active-low 7-segment controller: hex/raw mode, global blank,
// per-digit blink driven by a programmable half-period timer.

module seg7_digit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hex_we,
  input  logic       raw_we,
  input  logic       mask_we,
  input  logic [3:0] hex_d,
  input  logic [6:0] raw_d,
  input  logic       mask_d,
  input  logic       en,
  input  logic       dec,
  input  logic       phase,
  output logic [3:0] hex_q,
  output logic [6:0] raw_q,
  output logic       mask_q,
  output logic [6:0] seg_n
);
  logic [6:0] dig_val;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h40;  4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;  4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;  4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;  4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;  4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;  4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;  4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;  default: hex_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q  <= '0;
      raw_q  <= 7'h7F;
      mask_q <= 1'b0;
    end else begin
      if (hex_we)  hex_q  <= hex_d;
      if (raw_we)  raw_q  <= raw_d;
      if (mask_we) mask_q <= mask_d;
    end
  end

  always_comb begin
    dig_val = 7'h7F;
    if (en && !(mask_q && !phase))
      dig_val = dec ? hex_decode(hex_q) : raw_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seg_n <= 7'h7F;
    else          seg_n <= dig_val;
  end
endmodule

module seg7_display_ctrl #(
  parameter int          NUM_DIGITS    = 6,
  parameter logic [31:0] BLINK_DEFAULT = 32'd25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seg7_display_ctrl_if.slave      bus,
  output logic [7*NUM_DIGITS-1:0] seg_n,
  output logic                    blink_phase
);
  logic        we, we_ctrl, we_hex, we_lo, we_hi, we_div;
  logic        ctrl_en, ctrl_dec;
  logic [31:0] blink_div, cnt;
  logic        phase_r;

  logic [NUM_DIGITS-1:0][3:0] hex_q;
  logic [NUM_DIGITS-1:0][6:0] raw_q;
  logic [NUM_DIGITS-1:0]      mask_q;

  assign we      = bus.chipselect && !bus.write_n;
  assign we_ctrl = we && (bus.address == 3'd0);
  assign we_hex  = we && (bus.address == 3'd1);
  assign we_lo   = we && (bus.address == 3'd2);
  assign we_hi   = we && (bus.address == 3'd3);
  assign we_div  = we && (bus.address == 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_dec  <= 1'b1;
      blink_div <= BLINK_DEFAULT;
    end else begin
      if (we_ctrl) begin
        ctrl_en  <= bus.writedata[0];
        ctrl_dec <= bus.writedata[1];
      end
      if (we_div) blink_div <= bus.writedata;
    end
  end

  // A BLINK_DIV write restarts the half-period without touching the phase,
  // and wins over a wrap landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      phase_r <= 1'b1;
    end else if (we_div) begin
      cnt <= '0;
    end else if (blink_div == '0) begin
      cnt     <= '0;
      phase_r <= 1'b1;
    end else if (cnt == blink_div) begin
      cnt     <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  // Divider of zero shows the digits steadily from the edge it is written.
  assign blink_phase = phase_r | (blink_div == '0);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    localparam int RB = (g % 4) * 8;
    seg7_digit u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .hex_we  (we_hex),
      .raw_we  ((g < 4) ? we_lo : we_hi),
      .mask_we (we_ctrl),
      .hex_d   (bus.writedata[4*g +: 4]),
      .raw_d   (bus.writedata[RB +: 7]),
      .mask_d  (bus.writedata[8+g]),
      .en      (ctrl_en),
      .dec     (ctrl_dec),
      .phase   (blink_phase),
      .hex_q   (hex_q[g]),
      .raw_q   (raw_q[g]),
      .mask_q  (mask_q[g]),
      .seg_n   (seg_n[7*g +: 7])
    );
  end

  logic [7:0]      mask8;
  logic [7:0][3:0] hex8;
  logic [7:0][7:0] raw8;

  always_comb begin
    mask8 = '0;
    hex8  = '0;
    raw8  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      mask8[i] = mask_q[i];
      hex8[i]  = hex_q[i];
      raw8[i]  = {1'b0, raw_q[i]};
    end
    bus.readdata = '0;
    case (bus.address)
      3'd0: bus.readdata = {16'h0, mask8, 6'h0, ctrl_dec, ctrl_en};
      3'd1: bus.readdata = hex8;
      3'd2: bus.readdata = raw8[3:0];
      3'd3: bus.readdata = raw8[7:4];
      3'd4: bus.readdata = blink_div;
      3'd5: bus.readdata = {20'h0, 4'(NUM_DIGITS), 7'h0, blink_phase};
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomized self-checking bench for seg7_display_ctrl against a register/time model.
module tb_seg7_display_ctrl;
  localparam int          ND   = 6;
  localparam logic [31:0] BDEF = 32'd25000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg7_display_ctrl_if bus ();
  logic [7*ND-1:0] seg_n;
  logic            blink_phase;

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DEFAULT(BDEF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .seg_n(seg_n), .blink_phase(blink_phase));

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  always @(posedge clk) ecnt++;

  // Reference model: register contents plus blink phase as a function of edge number.
  bit        m_en, m_dec;
  bit [7:0]  m_mask;
  bit [3:0]  m_hex [8];
  bit [6:0]  m_raw [8];
  bit [31:0] m_div;
  int        anc_e;
  bit        anc_v;
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic bit m_phase(int e);
    longint per, k;
    if (m_div == 0) return 1'b1;
    per = longint'({32'h0, m_div}) + 1;
    k   = longint'(e - anc_e) / per;
    return anc_v ^ k[0];
  endfunction

  function automatic logic [7*ND-1:0] m_seg(int e);
    logic [7*ND-1:0] r;
    bit ph;
    ph = m_phase(e - 1);
    for (int i = 0; i < ND; i++) begin
      if (!m_en || (m_mask[i] && !ph)) r[7*i +: 7] = 7'h7F;
      else if (m_dec)                  r[7*i +: 7] = dec_tab[m_hex[i]];
      else                             r[7*i +: 7] = m_raw[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: begin r[0] = m_en; r[1] = m_dec; r[15:8] = m_mask; end
      1: for (int i = 0; i < ND; i++) r[4*i +: 4] = m_hex[i];
      2: for (int i = 0; i < ND && i < 4; i++) r[8*i +: 7] = m_raw[i];
      3: for (int i = 4; i < ND; i++) r[8*(i-4) +: 7] = m_raw[i];
      4: r = m_div;
      5: begin r[0] = m_phase(ecnt); r[11:8] = 4'(ND); end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_en = 0; m_dec = 1; m_mask = '0; m_div = BDEF;
    for (int i = 0; i < 8; i++) begin m_hex[i] = '0; m_raw[i] = 7'h7F; end
    anc_e = ecnt; anc_v = 1'b1;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(int a, logic [31:0] d);
    logic [31:0] dd;
    dd = d;
    bus.address = 3'(a); bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    case (a)
      0: begin
        m_en = dd[0]; m_dec = dd[1];
        for (int i = 0; i < 8; i++) m_mask[i] = (i < ND) ? dd[8+i] : 1'b0;
      end
      1: for (int i = 0; i < ND; i++) m_hex[i] = dd[4*i +: 4];
      2: for (int i = 0; i < ND && i < 4; i++) m_raw[i] = dd[8*i +: 7];
      3: for (int i = 4; i < ND; i++) m_raw[i] = dd[8*(i-4) +: 7];
      4: begin anc_v = m_phase(ecnt - 1); anc_e = ecnt; m_div = dd; end
      default: ;
    endcase
  endtask

  task automatic rd(int a, output logic [31:0] d);
    bus.address = 3'(a); bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [6] = '{32'h2, 32'h0, 32'h7F7F7F7F, 32'h00007F7F, BDEF, 32'h601};
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset_n = 1'b0;
    tick(3);
    total++;
    if (seg_n !== {7*ND{1'b1}}) begin bad++; $display("FAIL reset_seg: got %h want all ones", seg_n); end
    total++;
    if (blink_phase !== 1'b1) begin bad++; $display("FAIL reset_phase: got %b want 1", blink_phase); end
    reset_n = 1'b1;
    m_reset();
    for (int a = 0; a < 6; a++) begin
      rd(a, d);
      total++;
      if (d !== exp_rd[a]) begin bad++; $display("FAIL reset_reg%0d: got %h want %h", a, d, exp_rd[a]); end
    end
    rd(7, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_unused: got %h want 0", d); end
  endtask

  task automatic test_decode();
    logic [7*ND-1:0] old;
    wr(1, 32'h00543210);
    tick();
    old = m_seg(ecnt + 1);
    wr(0, 32'h3);
    total++;
    if (seg_n !== old) begin bad++; $display("FAIL decode_latency: got %h want %h", seg_n, old); end
    tick();
    total++;
    if (seg_n !== {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}) begin
      bad++; $display("FAIL decode_digits: got %h want %h", seg_n, {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
    end
  endtask

  task automatic test_raw();
    logic [31:0] d;
    wr(0, 32'h1);
    wr(2, 32'h0);
    tick();
    total++;
    if (seg_n !== {7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00}) begin
      bad++; $display("FAIL raw_digits: got %h want %h", seg_n, {7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00});
    end
    wr(3, 32'hFFFFFFFF);
    rd(3, d);
    total++;
    if (d !== 32'h00007F7F) begin bad++; $display("FAIL raw_hi_read: got %h want 00007f7f", d); end
  endtask

  task automatic test_blink();
    int   toggles;
    logic prev;
    wr(4, 32'd3);
    wr(0, 32'h0103);
    prev = blink_phase;
    toggles = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (blink_phase !== prev) toggles++;
      prev = blink_phase;
      total++;
      if (blink_phase !== m_phase(ecnt)) begin bad++; $display("FAIL blink_phase c%0d: got %b want %b", c, blink_phase, m_phase(ecnt)); end
      total++;
      if (seg_n !== m_seg(ecnt)) begin bad++; $display("FAIL blink_seg c%0d: got %h want %h", c, seg_n, m_seg(ecnt)); end
    end
    total++;
    if (toggles != 4) begin bad++; $display("FAIL blink_rate: got %0d toggles want 4", toggles); end
  endtask

  task automatic test_div_on_wrap();
    logic pre;
    int   guard;
    guard = 0;
    while (((ecnt + 1 - anc_e) % 4) != 0 && guard < 8) begin tick(); guard++; end
    pre = blink_phase;
    wr(4, 32'd3);
    total++;
    if (blink_phase !== pre) begin bad++; $display("FAIL wrap_write_hold: got %b want %b", blink_phase, pre); end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (blink_phase !== m_phase(ecnt)) begin bad++; $display("FAIL wrap_restart c%0d: got %b want %b", c, blink_phase, m_phase(ecnt)); end
      if (c == 2) begin
        total++;
        if (blink_phase !== pre) begin bad++; $display("FAIL wrap_no_early_toggle: got %b want %b", blink_phase, pre); end
      end
    end
    wr(4, 32'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (blink_phase !== 1'b1) begin bad++; $display("FAIL div0_hold c%0d: got %b want 1", c, blink_phase); end
    end
  endtask

  task automatic test_random();
    int          a, ra;
    logic [31:0] d;
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 7);
      d = (a == 4) ? 32'($urandom_range(0, 6)) : $urandom;
      wr(a, d);
      tick($urandom_range(1, 3));
      total++;
      if (seg_n !== m_seg(ecnt)) begin bad++; $display("FAIL rand_seg it%0d: got %h want %h", it, seg_n, m_seg(ecnt)); end
      total++;
      if (blink_phase !== m_phase(ecnt)) begin bad++; $display("FAIL rand_phase it%0d: got %b want %b", it, blink_phase, m_phase(ecnt)); end
      ra = $urandom_range(0, 7);
      rd(ra, d);
      total++;
      if (d !== m_read(ra)) begin bad++; $display("FAIL rand_read it%0d a%0d: got %h want %h", it, ra, d, m_read(ra)); end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    wr(4, 32'd2);
    wr(1, $urandom);
    wr(0, 32'h0103);
    tick(3);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (seg_n !== {7*ND{1'b1}}) begin bad++; $display("FAIL midreset_seg: got %h want all ones", seg_n); end
    total++;
    if (blink_phase !== 1'b1) begin bad++; $display("FAIL midreset_phase: got %b want 1", blink_phase); end
    rd(4, d);
    total++;
    if (d !== BDEF) begin bad++; $display("FAIL midreset_div: got %0d want %0d", d, BDEF); end
    tick();
    reset_n = 1'b1;
    m_reset();
    rd(0, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL midreset_ctrl: got %h want 2", d); end
    tick(2);
    total++;
    if (seg_n !== m_seg(ecnt)) begin bad++; $display("FAIL postreset_seg: got %h want %h", seg_n, m_seg(ecnt)); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_raw();
    wr(0, 32'h3);
    test_blink();
    test_div_on_wrap();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
